// File: rtl/csr_expander.sv
// csr_expander: re-densifies one CSR-encoded feature map into a
// raster-order pixel stream, one pixel per out_valid/out_ready transfer.
module csr_expander #(
  parameter int image_size         = 28,
  parameter int word_length        = 8,
  parameter int col_length         = 8,
  parameter int double_word_length = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [double_word_length-1:0]            valid_num,
  input  logic [image_size*image_size*word_length-1:0] data_in,
  input  logic [image_size*image_size*col_length-1:0]  data_in_cols,
  input  logic [image_size*image_size*col_length-1:0]  data_in_rows,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [word_length-1:0]                   out_pixel,
  output logic [col_length-1:0]                    out_row,
  output logic [col_length-1:0]                    out_col,
  output logic                                     out_last,
  output logic                                     err
);

  localparam int NPIX = image_size * image_size;
  localparam int KW   = $clog2(NPIX + 1);
  localparam int CW   = (col_length > KW) ? col_length : KW;
  localparam int DBW  = NPIX * word_length;
  localparam int CBW  = NPIX * col_length;
  localparam logic [CW-1:0] LAST = CW'(image_size - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state_q, state_d;

  logic [DBW-1:0]         data_q;
  logic [CBW-1:0]         cols_q;
  logic [CBW-1:0]         rows_q;
  logic [KW-1:0]          n_q, n_in;
  logic [KW-1:0]          k_q, k_d, k_tgt, k_fin, rd_idx;
  logic [CW-1:0]          row_q, row_d, col_q, col_d;
  logic [CW-1:0]          row_nxt, col_nxt, row_tgt, col_tgt;
  logic [word_length-1:0] pix_q, pix_d, ent_val;
  logic [col_length-1:0]  ent_row, ent_col;
  logic                   hit_q, hit_d, match;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic                   rdy_q, rdy_d;
  logic                   accept, xfer, prime, load, tgt_last;

  assign accept = (state_q == IDLE) && in_valid;
  assign xfer   = valid_q && out_ready;
  assign prime  = (state_q == STREAM) && !valid_q;
  assign load   = prime || (xfer && !last_q);

  always_comb begin
    if (32'(valid_num) > NPIX) n_in = KW'(NPIX);
    else                       n_in = KW'(valid_num);
  end

  always_comb begin
    if (col_q == LAST) begin
      col_nxt = '0;
      row_nxt = row_q + CW'(1);
    end else begin
      col_nxt = col_q + CW'(1);
      row_nxt = row_q;
    end
  end

  // The pixel being loaded is looked up one step ahead so outputs stay registered
  assign row_tgt = prime ? '0 : row_nxt;
  assign col_tgt = prime ? '0 : col_nxt;
  assign k_tgt   = prime ? '0 : k_q + KW'(hit_q);
  assign rd_idx  = (k_tgt < n_q) ? k_tgt : '0;

  assign ent_val = data_q[rd_idx*word_length +: word_length];
  assign ent_row = rows_q[rd_idx*col_length +: col_length];
  assign ent_col = cols_q[rd_idx*col_length +: col_length];

  assign match = (k_tgt < n_q)
              && (CW'(ent_row) == row_tgt)
              && (CW'(ent_col) == col_tgt);

  assign tgt_last = (row_tgt == LAST) && (col_tgt == LAST);
  assign k_fin    = k_tgt + KW'(match);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    hit_d   = hit_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          hit_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      STREAM: begin
        if (load) begin
          valid_d = 1'b1;
          pix_d   = match ? ent_val : '0;
          row_d   = row_tgt;
          col_d   = col_tgt;
          k_d     = k_tgt;
          hit_d   = match;
          last_d  = tgt_last;
          // err is decided when the last pixel is loaded so it is valid with out_last
          if (tgt_last) err_d = (k_fin != n_q);
        end else if (xfer) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          pix_d   = '0;
          row_d   = '0;
          col_d   = '0;
          hit_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= data_in;
      cols_q <= data_in_cols;
      rows_q <= data_in_rows;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      hit_q   <= 1'b0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) n_q <= n_in;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      hit_q   <= hit_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = valid_q;
  assign out_pixel = pix_q;
  assign out_row   = row_q[col_length-1:0];
  assign out_col   = col_q[col_length-1:0];
  assign out_last  = last_q;
  assign err       = err_q;

endmodule

// File: doc/csr_expander.md
# csr_expander

Decompresses one CSR-encoded feature map into a dense raster-order pixel stream, one pixel per accepted transfer. It is the decode direction of the feature CSR encoder. It takes the same packed value/col/row buses and valid count that the encoder emits. It sits wherever a compressed map must be re-densified, e.g. for debug readback, golden-model comparison, or feeding dense-only downstream stages.

## Interface
- image_size, 28, map is image_size × image_size pixels
- word_length, 8, pixel value width
- col_length, 8, row/col index width per entry
- double_word_length, 16, width of valid_num
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  CSR bundle present; accepted only when in_ready=1
- in_ready  out  1  block idle and able to accept a bundle
- valid_num  in  double_word_length  number of valid CSR entries
- data_in  in  image_size²·word_length  entry k value at [k·word_length +: word_length]
- data_in_cols  in  image_size²·col_length  entry k column at [k·col_length +: col_length]
- data_in_rows  in  image_size²·col_length  entry k row, same packing
- out_valid  out  1  out_pixel/out_row/out_col valid
- out_ready  in  1  downstream accepts the current pixel
- out_pixel  out  word_length  dense pixel value (0 where no entry)
- out_row, out_col  out  col_length each  raster coordinate of out_pixel
- out_last  out  1  high with the final pixel (image_size−1, image_size−1)
- err  out  1  sticky malformed-bundle flag, valid when out_last transfers

## Operation
- States: IDLE, STREAM.
- **IDLE**
  - in_ready=1.
  - On in_valid: latch all four input buses into internal storage, clear err, set row=col=0 and entry pointer k=0, then go to STREAM.
- **STREAM**
  - in_ready=0; in_valid is ignored.
- **Effective entry count**
  - n = min(valid_num, image_size²).
  - Entries k≥n are never read.
- **Per pixel** (presented while out_valid=1):
  - If k<n and rows[k]==row and cols[k]==col: out_pixel=data[k]. k advances on transfer.
  - Otherwise: out_pixel=0, and k is unchanged.
- **Transfer** = out_valid & out_ready on a rising edge.
  - col increments on each transfer. It wraps to 0 at image_size−1, and row increments on the wrap.
- **Ordering requirement**
  - Entries must be in strict raster order (row-major, ascending), as the encoder produces them.
  - A duplicate or out-of-order entry is never matched.
  - On the last transfer, if the final k ≠ n, err is set.
  - err holds until the next bundle is accepted.
- **Last pixel**
  - out_last=1 only when row=col=image_size−1.
  - Its transfer returns the block to IDLE; out_valid falls in the same edge.
- **Width rules**
  - Coordinates compare on the full col_length bits.
  - k and the coordinate counters must be wide enough for image_size² (≥10 bits at the defaults).

## Timing
- Reset values: in_ready=1, out_valid=0, out_pixel=0, out_row=0, out_col=0, out_last=0, err=0, state IDLE.
- All outputs are registered.
- **Latency**
  - A bundle accepted at edge N gives out_valid=1 with pixel (0,0) after edge N+1.
  - Throughput is one pixel per cycle while out_ready=1.
  - A full map takes image_size² transfer cycles, plus 1 cycle from acceptance.
- **Handshake**
  - While out_valid=1 and out_ready=0, out_pixel, out_row, out_col and out_last hold stable.
  - out_valid never drops before its transfer.
- **Return to idle**
  - in_ready rises on the edge after the last transfer.
  - A new in_valid may be accepted on that following edge, giving one idle cycle minimum between maps.
- **Reset mid-stream**: aborts immediately to reset values. Partial output is discarded and no out_last is produced.
- **Input stability**: input buses may change freely after acceptance, because storage is latched.

## Test plan
- valid_num=0 -> 784 transfers, all out_pixel=0, out_last only on (27,27), err=0, in_ready=1 next cycle.
- Single entry (0,0)=0x7F -> first pixel 0x7F, remaining 783 pixels 0, err=0.
- Entries (0,5)=0x11, (13,27)=0x22, (27,27)=0x80 with out_ready=1 -> the three values appear at raster indices 5, 391 and 783 (the last), all other pixels 0, total 785 cycles from accept to in_ready.
- Same bundle with out_ready toggled 1,0,0,1… -> identical pixel sequence; outputs stable during every stall; no lost or duplicated pixels.
- Out-of-order bundle (3,3)=0x01 then (1,1)=0x02, valid_num=2 -> (3,3)=0x01 emitted, (1,1) emitted as 0, err=1 at out_last.
- Assert rst low at pixel 100, release, then send a new bundle while asserting in_valid again mid-stream -> outputs return to reset values; the second in_valid during STREAM is ignored; the new map restarts at (0,0).
